my_dmux_stream: RTL and testbench
=================================

MY_DMUX_STREAM -- requirements
Module: my_dmux_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data bits per word.
REQ-002 SHALL provide parameter WAYS, default 8: output channel count, power of two, 2..64.
REQ-003 SHALL provide parameter SEL_W, default 3: select width, equal to log2(WAYS).
REQ-004 SHALL provide port clk  input  1  rising-edge clock; the block's single clock.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port in_data  input  WIDTH  word to route.
REQ-007 SHALL provide port in_sel  input  SEL_W  destination way index.
REQ-008 SHALL provide port in_bcast  input  1  send the word to all ways; present only with MY_DMUX_STREAM_BCAST_EN.
REQ-009 SHALL provide port in_valid  input  1  word offered.
REQ-010 SHALL provide port in_ready  output  1  block can take a word.
REQ-011 SHALL provide port out_data  output  WIDTH  held word, shared by all ways.
REQ-012 SHALL provide port out_valid  output  WAYS  per-way valid; bit k drives way k.
REQ-013 SHALL provide port out_ready  input  WAYS  per-way ready.
REQ-014 SHALL provide port busy  output  1  set while any pending bit is set.

Function
REQ-015 SHALL hold one word in a single output register, plus a WAYS-bit pending mask; out_valid SHALL equal the pending mask.
REQ-016 SHALL deliver way k on a cycle where out_valid[k] and out_ready[k] are both high; that pending bit SHALL clear at that edge.
REQ-017 SHALL drive in_ready = 1 when the mask is zero, or when every set pending bit delivers this cycle (combinational from out_ready).
REQ-018 SHALL accept a word on an edge where in_valid and in_ready are both high: load out_data, and set pending to one-hot(in_sel), or to all ones when broadcast.
REQ-019 SHALL make an accepted word visible on out_valid the following cycle, a latency of 1.
REQ-020 SHALL sustain 1 word per cycle when the targeted out_ready is held high.
REQ-021 SHALL give a new accept priority over clearing on the same edge: the mask SHALL take the new word's value.
REQ-022 SHALL NOT let out_data change while any pending bit is set.
REQ-023 SHALL NOT let any out_valid bit drop before its handshake completes; out_ready on a non-pending way SHALL be ignored.
REQ-024 SHALL drive busy = OR of the pending mask.

Reset
REQ-025 SHALL, while reset is high at an edge, clear the pending mask, out_data and busy to 0; in_ready SHALL then read 1.
REQ-026 SHALL abandon any in-flight word on reset mid-delivery, and accept nothing on a reset edge.

Configuration
REQ-027 SHALL compile in broadcast when MY_DMUX_STREAM_BCAST_EN is defined: in_bcast = 1 at accept sets all WAYS pending bits; each way completes independently; the next word is accepted only once all bits clear, per REQ-017.
REQ-028 SHALL omit in_bcast when MY_DMUX_STREAM_BCAST_EN is undefined, and every accept SHALL be one-hot.

Verification
REQ-029 SHALL cover: after reset, with all out_ready high, in_data=0xA5, in_sel=5 held 1 cycle -> next cycle out_valid=0x20, out_data=0xA5; the cycle after, out_valid=0x00.
REQ-030 SHALL cover: out_ready=0x00, send 0x11 to way 2 -> out_valid=0x04 held and in_ready=0 for 10 cycles; out_ready[2]=1 -> in_ready=1 in the same cycle.
REQ-031 SHALL cover: streaming 0x01..0x08 to ways 0..7 with out_ready=0xFF -> one accept per cycle, 8 deliveries in 8 consecutive cycles, in order.
REQ-032 SHALL cover (BCAST_EN): broadcast 0x3C with out_ready=0x0F, then 0xF0 -> mask 0xFF, then 0xF0, then 0x00; in_ready=1 only on the final cycle.
REQ-033 SHALL cover: reset asserted with out_valid=0x08 pending -> next cycle out_valid=0x00, out_data=0x00, busy=0, in_ready=1.
REQ-034 SHALL cover: word A pending on way 1, out_ready[1]=1 and word B offered to way 6 the same cycle -> next cycle out_valid=0x40, out_data=B.

Source files
------------

// File: rtl/my_dmux_stream.sv
// Routes one word from the input stream to one way, or to all ways when MY_DMUX_STREAM_BCAST_EN is defined.
// Latency 1: an accepted word appears on out_valid the next cycle; 1 word/cycle when the target way is ready.
// Backpressure: in_ready is low while any pending way will still be pending after this edge.
module my_dmux_stream #(
   parameter int WIDTH = 8,
   parameter int WAYS  = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_sel,
`ifdef MY_DMUX_STREAM_BCAST_EN
   input  logic             in_bcast,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WAYS-1:0]  out_valid,
   input  logic [WAYS-1:0]  out_ready,
   output logic             busy
);

   logic [WIDTH-1:0] data_q;
   logic [WAYS-1:0]  pend_q;
   logic [WAYS-1:0]  remaining;
   logic [WAYS-1:0]  new_mask;
   logic             accept;

   // Ways still waiting after this edge; out_ready on idle ways drops out here.
   assign remaining = pend_q & ~out_ready;
   assign in_ready  = (remaining == '0);
   assign accept    = in_valid & in_ready;

   // Destination mask for an incoming word: one-hot, or all ways on broadcast.
   always_comb begin
      new_mask = {{(WAYS-1){1'b0}}, 1'b1} << in_sel;
`ifdef MY_DMUX_STREAM_BCAST_EN
      if (in_bcast) begin
         new_mask = '1;
      end
`endif
   end

   // Holding register and pending mask; a new accept overrides the clearing of delivered bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         pend_q <= '0;
      end else if (accept) begin
         data_q <= in_data;
         pend_q <= new_mask;
      end else begin
         pend_q <= remaining;
      end
   end

   assign out_data  = data_q;
   assign out_valid = pend_q;
   assign busy      = |pend_q;

endmodule

// File: tb/tb_my_dmux_stream.sv
// Directed bench for my_dmux_stream (WIDTH=8, WAYS=8); broadcast steps run only with MY_DMUX_STREAM_BCAST_EN.
// Inputs change and outputs are sampled 2 time units after the rising edge.
// Combinational in_ready is sampled 1 time unit after its inputs change.
module tb_my_dmux_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic [2:0] in_sel;
`ifdef MY_DMUX_STREAM_BCAST_EN
   logic       in_bcast;
`endif
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic [7:0] out_valid;
   logic [7:0] out_ready;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   my_dmux_stream #(.WIDTH(8), .WAYS(8), .SEL_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
`ifdef MY_DMUX_STREAM_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = 8'h00;
      in_sel    = 3'd0;
`ifdef MY_DMUX_STREAM_BCAST_EN
      in_bcast  = 1'b0;
`endif
      in_valid  = 1'b0;
      out_ready = 8'hFF;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_out_valid", 16'(out_valid), 16'h00);
      chk("rst_out_data",  16'(out_data),  16'h00);
      chk("rst_busy",      16'(busy),      16'h0);
      chk("rst_in_ready",  16'(in_ready),  16'h1);

      // single word to way 5, latency 1, delivered immediately
      in_data  = 8'hA5;
      in_sel   = 3'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("w5_out_valid", 16'(out_valid), 16'h20);
      chk("w5_out_data",  16'(out_data),  16'hA5);
      chk("w5_busy",      16'(busy),      16'h1);
      tick();
      chk("w5_done_valid", 16'(out_valid), 16'h00);
      chk("w5_done_data",  16'(out_data),  16'hA5);
      chk("w5_done_ready", 16'(in_ready),  16'h1);

      // stalled way 2: held for 10 cycles, ready on other ways ignored
      out_ready = 8'h00;
      in_data   = 8'h11;
      in_sel    = 3'd2;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) out_ready = 8'hFB;
         #1;
         chk("stall_out_valid", 16'(out_valid), 16'h04);
         chk("stall_in_ready",  16'(in_ready),  16'h0);
         chk("stall_out_data",  16'(out_data),  16'h11);
         tick();
      end
      out_ready = 8'h04;
      #1;
      chk("stall_release_in_ready", 16'(in_ready),  16'h1);
      chk("stall_release_valid",    16'(out_valid), 16'h04);
      tick();
      chk("stall_after_valid", 16'(out_valid), 16'h00);

      // back-to-back stream 0x01..0x08 to ways 0..7
      out_ready = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         in_data  = 8'(i + 1);
         in_sel   = 3'(i);
         in_valid = 1'b1;
         #1;
         chk("stream_in_ready", 16'(in_ready), 16'h1);
         tick();
         chk("stream_out_valid", 16'(out_valid), 16'(8'h01 << i));
         chk("stream_out_data",  16'(out_data),  16'(i + 1));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", 16'(out_valid), 16'h00);

      // accept wins over clearing: A on way 1 delivers while B to way 6 is accepted
      out_ready = 8'h00;
      in_data   = 8'h5A;
      in_sel    = 3'd1;
      in_valid  = 1'b1;
      tick();
      chk("prio_a_valid", 16'(out_valid), 16'h02);
      out_ready = 8'h02;
      in_data   = 8'hC3;
      in_sel    = 3'd6;
      #1;
      chk("prio_in_ready", 16'(in_ready), 16'h1);
      tick();
      out_ready = 8'h00;
      chk("prio_b_valid", 16'(out_valid), 16'h40);
      chk("prio_b_data",  16'(out_data),  16'hC3);

      // data held while pending: offered word is refused
      in_data = 8'hEE;
      in_sel  = 3'd0;
      #1;
      chk("hold_in_ready", 16'(in_ready), 16'h0);
      tick();
      in_valid = 1'b0;
      chk("hold_out_data",  16'(out_data),  16'hC3);
      chk("hold_out_valid", 16'(out_valid), 16'h40);

      // reset mid-delivery abandons the word and accepts nothing
      out_ready = 8'hFF;
      tick();
      out_ready = 8'h00;
      in_data   = 8'h77;
      in_sel    = 3'd3;
      in_valid  = 1'b1;
      tick();
      chk("prerst_valid", 16'(out_valid), 16'h08);
      reset    = 1'b1;
      out_ready = 8'hFF;
      in_data  = 8'h99;
      in_sel   = 3'd0;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("midrst_out_valid", 16'(out_valid), 16'h00);
      chk("midrst_out_data",  16'(out_data),  16'h00);
      chk("midrst_busy",      16'(busy),      16'h0);
      chk("midrst_in_ready",  16'(in_ready),  16'h1);

`ifdef MY_DMUX_STREAM_BCAST_EN
      // broadcast 0x3C, ways complete independently
      out_ready = 8'h00;
      in_data   = 8'h3C;
      in_bcast  = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      chk("bc_mask_ff", 16'(out_valid), 16'hFF);
      chk("bc_data",    16'(out_data),  16'h3C);
      out_ready = 8'h0F;
      #1;
      chk("bc_ready_0", 16'(in_ready), 16'h0);
      tick();
      chk("bc_mask_f0", 16'(out_valid), 16'hF0);
      out_ready = 8'hF0;
      #1;
      chk("bc_ready_1", 16'(in_ready), 16'h1);
      tick();
      chk("bc_mask_00", 16'(out_valid), 16'h00);
      chk("bc_ready_2", 16'(in_ready),  16'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
